ooo_commit_trace_unit: RTL
==========================

// Module: ooo_commit_trace_unit
// PURPOSE
//  Synthesizable commit tracer for the out-of-order core; replaces ad-hoc bench $monitor probing.
//  Sits beside the ROB commit port and CDB, and captures up to COMMIT_WIDTH retirements per cycle into a ring buffer.
//  The ring buffer drains over a valid/ready port. Also keeps retire/cycle/CDB counters and a no-commit watchdog.
// PARAMETERS
//  XLEN          32  data/PC width
//  AREG_BITS     5   architectural register index width
//  PTAG_BITS     6   CDB physical tag width
//  COMMIT_WIDTH  2   commit lanes per cycle (1..TRACE_DEPTH)
//  TRACE_DEPTH   16  ring entries, power of 2
//  WDOG_CYCLES   64  consecutive commit-free cycles before hang asserts
// PORTS
//  clk            in   1                  clock, rising edge
//  reset_n        in   1                  synchronous reset, active-low
//  commit_valid   in   COMMIT_WIDTH       per-lane retire strobe; lane 0 is oldest
//  commit_we      in   COMMIT_WIDTH       lane writes arch RF
//  commit_pc      in   COMMIT_WIDTH*XLEN  lane i at [i*XLEN +: XLEN]
//  commit_rd      in   COMMIT_WIDTH*AREG_BITS  destination arch reg per lane
//  commit_data    in   COMMIT_WIDTH*XLEN  writeback value per lane
//  cdb_valid      in   1                  CDB broadcast strobe
//  cdb_tag        in   PTAG_BITS          CDB tag (counted only)
//  freeze         in   1                  suspend capture
//  trace_valid    out  1                  head entry available
//  trace_ready    in   1                  pop head when trace_valid
//  trace_seq      out  16                 head sequence number
//  trace_pc/trace_data out XLEN           head entry fields
//  trace_rd       out  AREG_BITS          head entry field
//  trace_we       out  1                  head entry field
//  trace_count    out  $clog2(DEPTH)+1    occupancy
//  overflow       out  1                  sticky, entries were dropped
//  hang           out  1                  sticky, watchdog expired
//  retired_count, cycle_count, cdb_count  out 32  free-running counters, wrap at 2^32
//  shadow_addr    in   AREG_BITS          shadow RF read address (see CONFIGURATION)
//  shadow_data    out  XLEN               shadow RF read data
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): pointers, counts, seq, counters, overflow, hang, shadow RF all 0; trace_valid=0.
//  - Capture: valid lanes packed in lane order into consecutive slots, each tagged with the running 16-bit seq.
//    seq increments per captured entry and wraps 0xFFFF->0. No capture and no seq/retired update while freeze=1.
//  - Timing: an entry captured at edge N is visible at head no earlier than after edge N.
//    trace_* outputs are combinational from the head slot (show-ahead); a pop takes effect at the edge with trace_valid&trace_ready.
//  - Same-cycle pop+push: pop applied first. next = count - pop + n_push.
//    If next > DEPTH: the (next-DEPTH) oldest entries are discarded (head advances), count=DEPTH, and overflow is set.
//    A seq gap at readout marks the loss.
//  - Empty: trace_valid=0 and trace_ready is ignored. Pointers wrap mod DEPTH.
//  - retired_count += popcount(commit_valid) when not frozen; cycle_count +1 every cycle (also while frozen);
//    cdb_count +1 per cdb_valid.
//  - Watchdog: counter clears on any commit_valid bit, otherwise saturating increment.
//    hang is set when the counter reaches WDOG_CYCLES. Only reset clears hang and overflow. Watchdog is held at 0 while frozen.
// CONFIGURATION
//  TRACE_ARCH_SHADOW_EN defined:
//  - 2^AREG_BITS x XLEN shadow arch RF, updated on unfrozen commits with we=1 and rd!=0.
//  - Same rd in several lanes in one cycle: highest lane wins.
//  - shadow_data = shadow[shadow_addr] combinationally; x0 reads 0.
//  Undefined: no storage, and shadow_data ties to 0.
// TESTING
//  1 reset_n=0 2 cycles -> all outputs 0, trace_valid=0, trace_count=0.
//  2 lanes0/1 pc=0x0/0x4 same cycle -> next cycle count=2; pops give seq0 pc0x0, then seq1 pc0x4.
//  3 ready=0, 18 single-lane commits, DEPTH=16 -> overflow=1, count=16, head seq=2.
//  4 no commits 64 cycles -> hang=1 on 64th; later commit clears watchdog counter, but hang stays 1.
//  5 freeze=1, 3 commits + 3 CDB pulses -> count, seq, retired unchanged; cdb_count+=3; cycle_count still advances.
//  6 (macro) lane0 x1=0xDEADBEEF, lane1 x1=0x12345678 same cycle; rd=0 write 0xFFFFFFFF -> shadow x1=0x12345678, x0=0.

Source files
------------

// File: rtl/ooo_commit_trace_unit_if.sv
// Commit-port, CDB and trace-drain bundle for ooo_commit_trace_unit.
// slave = tracer side, master = core / trace consumer side.
interface ooo_commit_trace_unit_if #(
    parameter int XLEN         = 32,
    parameter int AREG_BITS    = 5,
    parameter int PTAG_BITS    = 6,
    parameter int COMMIT_WIDTH = 2
);
    logic [COMMIT_WIDTH-1:0]           commit_valid;
    logic [COMMIT_WIDTH-1:0]           commit_we;
    logic [COMMIT_WIDTH*XLEN-1:0]      commit_pc;
    logic [COMMIT_WIDTH*AREG_BITS-1:0] commit_rd;
    logic [COMMIT_WIDTH*XLEN-1:0]      commit_data;
    logic                              cdb_valid;
    logic [PTAG_BITS-1:0]              cdb_tag;
    logic                              freeze;
    logic                              trace_valid;
    logic                              trace_ready;
    logic [15:0]                       trace_seq;
    logic [XLEN-1:0]                   trace_pc;
    logic [XLEN-1:0]                   trace_data;
    logic [AREG_BITS-1:0]              trace_rd;
    logic                              trace_we;

    modport slave (
        input  commit_valid, commit_we, commit_pc, commit_rd, commit_data,
        input  cdb_valid, cdb_tag, freeze, trace_ready,
        output trace_valid, trace_seq, trace_pc, trace_data, trace_rd, trace_we
    );

    modport master (
        output commit_valid, commit_we, commit_pc, commit_rd, commit_data,
        output cdb_valid, cdb_tag, freeze, trace_ready,
        input  trace_valid, trace_seq, trace_pc, trace_data, trace_rd, trace_we
    );
endinterface

// File: rtl/ooo_commit_trace_unit.sv
// Commit tracer: packs retirements into a ring buffer with seq tags, plus counters and a no-commit watchdog.
// Optional shadow architectural register file enabled by macro TRACE_ARCH_SHADOW_EN.
module ooo_commit_trace_unit #(
    parameter int XLEN         = 32,
    parameter int AREG_BITS    = 5,
    parameter int PTAG_BITS    = 6,
    parameter int COMMIT_WIDTH = 2,
    parameter int TRACE_DEPTH  = 16,
    parameter int WDOG_CYCLES  = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    ooo_commit_trace_unit_if.slave        tif,
    output logic [$clog2(TRACE_DEPTH):0]  trace_count,
    output logic                          overflow,
    output logic                          hang,
    output logic [31:0]                   retired_count,
    output logic [31:0]                   cycle_count,
    output logic [31:0]                   cdb_count,
    input  logic [AREG_BITS-1:0]          shadow_addr,
    output logic [XLEN-1:0]               shadow_data
);
    localparam int PTR_W  = $clog2(TRACE_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SUM_W  = CNT_W + 1;
    localparam int LCNT_W = $clog2(COMMIT_WIDTH + 1);
    localparam int WD_W   = $clog2(WDOG_CYCLES + 1);

    typedef struct packed {
        logic [15:0]          seq;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      data;
        logic [AREG_BITS-1:0] rd;
        logic                 we;
    } entry_t;

    entry_t               mem_r [TRACE_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [15:0]          seq_r;
    logic                 overflow_r;
    logic                 hang_r;
    logic [WD_W-1:0]      wdog_r;
    logic [31:0]          retired_r;
    logic [31:0]          cycle_r;
    logic [31:0]          cdb_r;

    logic [COMMIT_WIDTH-1:0] cap_s;
    logic [PTR_W-1:0]        off_s [COMMIT_WIDTH];
    logic [LCNT_W-1:0]       n_push_s;
    logic                    pop_s;
    logic [SUM_W-1:0]        next_s;
    logic [SUM_W-1:0]        drop_s;
    logic [CNT_W-1:0]        count_nxt_s;
    logic                    ovf_set_s;
    logic [WD_W-1:0]         wdog_nxt_s;
    entry_t                  head_s;
    logic                    cdb_tag_unused_s;

    assign cdb_tag_unused_s = ^tif.cdb_tag;

    // Lane packing offsets, occupancy update and oldest-entry discard on overflow.
    always_comb begin
        cap_s    = tif.freeze ? {COMMIT_WIDTH{1'b0}} : tif.commit_valid;
        n_push_s = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            off_s[i] = PTR_W'(n_push_s);
            n_push_s = n_push_s + LCNT_W'(cap_s[i]);
        end
        pop_s  = (count_r != '0) && tif.trace_ready;
        next_s = SUM_W'(count_r) - SUM_W'(pop_s) + SUM_W'(n_push_s);
        if (next_s > SUM_W'(TRACE_DEPTH)) begin
            drop_s      = next_s - SUM_W'(TRACE_DEPTH);
            count_nxt_s = CNT_W'(TRACE_DEPTH);
            ovf_set_s   = 1'b1;
        end else begin
            drop_s      = '0;
            count_nxt_s = next_s[CNT_W-1:0];
            ovf_set_s   = 1'b0;
        end
    end

    // Watchdog: freeze and any retire strobe clear it, otherwise saturating count.
    always_comb begin
        if (tif.freeze) begin
            wdog_nxt_s = '0;
        end else if (|tif.commit_valid) begin
            wdog_nxt_s = '0;
        end else if (wdog_r == WD_W'(WDOG_CYCLES)) begin
            wdog_nxt_s = wdog_r;
        end else begin
            wdog_nxt_s = wdog_r + WD_W'(1'b1);
        end
    end

    // Control state, sticky flags and free-running counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            seq_r      <= 16'd0;
            overflow_r <= 1'b0;
            hang_r     <= 1'b0;
            wdog_r     <= '0;
            retired_r  <= 32'd0;
            cycle_r    <= 32'd0;
            cdb_r      <= 32'd0;
        end else begin
            rd_ptr_r   <= rd_ptr_r + PTR_W'(pop_s) + PTR_W'(drop_s);
            wr_ptr_r   <= wr_ptr_r + PTR_W'(n_push_s);
            count_r    <= count_nxt_s;
            seq_r      <= seq_r + 16'(n_push_s);
            overflow_r <= overflow_r | ovf_set_s;
            wdog_r     <= wdog_nxt_s;
            hang_r     <= hang_r | (wdog_nxt_s == WD_W'(WDOG_CYCLES));
            retired_r  <= retired_r + 32'(n_push_s);
            cycle_r    <= cycle_r + 32'd1;
            cdb_r      <= cdb_r + 32'(tif.cdb_valid);
        end
    end

    // Ring storage: valid lanes land in consecutive slots from the write pointer.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (cap_s[i]) begin
                    mem_r[wr_ptr_r + off_s[i]] <= '{
                        seq:  seq_r + 16'(off_s[i]),
                        pc:   tif.commit_pc[i*XLEN +: XLEN],
                        data: tif.commit_data[i*XLEN +: XLEN],
                        rd:   tif.commit_rd[i*AREG_BITS +: AREG_BITS],
                        we:   tif.commit_we[i]
                    };
                end
            end
        end
    end

    assign head_s = mem_r[rd_ptr_r];

    // Show-ahead head; fields forced to zero while the ring is empty.
    always_comb begin
        if (count_r != '0) begin
            tif.trace_valid = 1'b1;
            tif.trace_seq   = head_s.seq;
            tif.trace_pc    = head_s.pc;
            tif.trace_data  = head_s.data;
            tif.trace_rd    = head_s.rd;
            tif.trace_we    = head_s.we;
        end else begin
            tif.trace_valid = 1'b0;
            tif.trace_seq   = 16'd0;
            tif.trace_pc    = '0;
            tif.trace_data  = '0;
            tif.trace_rd    = '0;
            tif.trace_we    = 1'b0;
        end
    end

    assign trace_count   = count_r;
    assign overflow      = overflow_r;
    assign hang          = hang_r;
    assign retired_count = retired_r;
    assign cycle_count   = cycle_r;
    assign cdb_count     = cdb_r;

`ifdef TRACE_ARCH_SHADOW_EN
    logic [XLEN-1:0] shadow_r [2**AREG_BITS];

    // Lanes are visited oldest first, so the highest lane's write to a shared rd lands last.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int r = 0; r < 2**AREG_BITS; r++) begin
                shadow_r[r] <= '0;
            end
        end else if (!tif.freeze) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (tif.commit_valid[i] && tif.commit_we[i] &&
                    (tif.commit_rd[i*AREG_BITS +: AREG_BITS] != '0)) begin
                    shadow_r[tif.commit_rd[i*AREG_BITS +: AREG_BITS]] <= tif.commit_data[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Shadow read port with x0 hardwired to zero.
    always_comb begin
        if (shadow_addr == '0) begin
            shadow_data = '0;
        end else begin
            shadow_data = shadow_r[shadow_addr];
        end
    end
`else
    logic shadow_addr_unused_s;
    assign shadow_addr_unused_s = ^shadow_addr;
    assign shadow_data          = '0;
`endif
endmodule
